// File: rtl/decoder_2to4_if.sv
// decoder_2to4_if: bundles the index/enable inputs and the decoded outputs
// of decoder_2to4. The DUT side uses the slave modport and the driving side
// uses the master modport.
// Optional feature macro: DECODER_2TO4_HIT_CNT_EN adds the o_hit_cnt bus.
interface decoder_2to4_if #(
    parameter int CNT_WIDTH = 8
);
    logic [1:0] i_binary;
    logic       i_en;
    logic [3:0] o_one_hot;
    logic [3:0] o_one_hot_q;
    logic       o_valid_q;
`ifdef DECODER_2TO4_HIT_CNT_EN
    logic [4*CNT_WIDTH-1:0] o_hit_cnt;

    modport master (
        output i_binary,
        output i_en,
        input  o_one_hot,
        input  o_one_hot_q,
        input  o_valid_q,
        input  o_hit_cnt
    );

    modport slave (
        input  i_binary,
        input  i_en,
        output o_one_hot,
        output o_one_hot_q,
        output o_valid_q,
        output o_hit_cnt
    );
`else
    modport master (
        output i_binary,
        output i_en,
        input  o_one_hot,
        input  o_one_hot_q,
        input  o_valid_q
    );

    modport slave (
        input  i_binary,
        input  i_en,
        output o_one_hot,
        output o_one_hot_q,
        output o_valid_q
    );
`endif
endinterface

// File: rtl/decoder_2to4.sv
// decoder_2to4: 2-bit binary index to 4-bit one-hot decoder.
// o_one_hot is purely combinational. A registered copy (o_one_hot_q) and a
// one-cycle valid pulse (o_valid_q) are captured on edges where i_en is high.
// Optional feature macro: DECODER_2TO4_HIT_CNT_EN compiles in four saturating
// per-line hit counters driven out on o_hit_cnt.
module decoder_2to4 #(
    parameter int CNT_WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    decoder_2to4_if.slave  bus
);

    logic [3:0] w_one_hot;
    logic [3:0] r_one_hot_p1;
    logic       r_vld_p1;

    // Combinational decode; an X/Z index shifts to 4'bxxxx with no masking.
    always_comb begin
        w_one_hot = 4'b0001 << bus.i_binary;
    end

    assign bus.o_one_hot   = w_one_hot;
    assign bus.o_one_hot_q = r_one_hot_p1;
    assign bus.o_valid_q   = r_vld_p1;

    // Stage p1: capture the decoded word on enabled edges; valid is a per-sample pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_one_hot_p1 <= 4'b0000;
            r_vld_p1     <= 1'b0;
        end else begin
            r_vld_p1 <= bus.i_en;
            if (bus.i_en) begin
                r_one_hot_p1 <= w_one_hot;
            end
        end
    end

`ifdef DECODER_2TO4_HIT_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]   r_hit_cnt_p1 [4];
    logic [4*CNT_WIDTH-1:0] w_hit_cnt;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        if (val == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = val + 1'b1;
        end
    endfunction

    // Stage p1: only the line selected by the decoded word counts, so at most one changes per edge.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_rst) begin
                r_hit_cnt_p1[k] <= '0;
            end else if (bus.i_en && w_one_hot[k]) begin
                r_hit_cnt_p1[k] <= sat_inc(r_hit_cnt_p1[k]);
            end
        end
    end

    // Pack the four counters, line k at bits [k*CNT_WIDTH +: CNT_WIDTH].
    always_comb begin
        w_hit_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            w_hit_cnt[k*CNT_WIDTH +: CNT_WIDTH] = r_hit_cnt_p1[k];
        end
    end

    assign bus.o_hit_cnt = w_hit_cnt;
`else
    // No counters in this build; the combinational and registered paths above are unchanged.
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4: directed scenarios plus randomized
// traffic checked against a behavioural model of the decoder.
module tb_decoder_2to4;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    logic clk_run;

    int n_checks;
    int n_errors;

    // behavioural model state
    logic [3:0] m_q;
    logic       m_vld;
    int         m_cnt [4];

    decoder_2to4_if #(.CNT_WIDTH(CW)) bus ();

    decoder_2to4 #(.CNT_WIDTH(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_one_hot(input int idx);
        exp_one_hot = 4'(2 ** idx);
    endfunction

    // Drive one cycle of inputs, advance one edge, update the model, settle.
    task automatic tick(input logic r, input logic en, input logic [1:0] b);
        rst          = r;
        bus.i_en     = en;
        bus.i_binary = b;
        @(posedge clk);
        if (r) begin
            m_q   = 4'b0000;
            m_vld = 1'b0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else if (en) begin
            m_q   = exp_one_hot(int'(b));
            m_vld = 1'b1;
            if (m_cnt[b] < CNT_MAX) m_cnt[b] = m_cnt[b] + 1;
        end else begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    task automatic test_comb_sweep();
        for (int i = 0; i < 4; i++) begin
            bus.i_binary = 2'(i);
            #10;
            n_checks++;
            if (bus.o_one_hot !== exp_one_hot(i)) begin
                n_errors++;
                $display("FAIL comb_sweep idx=%0d: got %b expected %b", i, bus.o_one_hot, exp_one_hot(i));
            end
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 2'b11);
        n_checks++;
        if (bus.o_one_hot_q !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_q: got %b expected 0000", bus.o_one_hot_q);
        end
        n_checks++;
        if (bus.o_valid_q !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b expected 0", bus.o_valid_q);
        end
        n_checks++;
        if (bus.o_one_hot !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_comb: got %b expected 1000", bus.o_one_hot);
        end
`ifdef DECODER_2TO4_HIT_CNT_EN
        n_checks++;
        if (bus.o_hit_cnt !== '0) begin
            n_errors++;
            $display("FAIL reset_cnt: got %h expected 0", bus.o_hit_cnt);
        end
`endif
    endtask

    task automatic test_registered();
        tick(1'b0, 1'b1, 2'b10);
        n_checks++;
        if (bus.o_one_hot_q !== 4'b0100) begin
            n_errors++;
            $display("FAIL reg_capture_q: got %b expected 0100", bus.o_one_hot_q);
        end
        n_checks++;
        if (bus.o_valid_q !== 1'b1) begin
            n_errors++;
            $display("FAIL reg_capture_valid: got %b expected 1", bus.o_valid_q);
        end
        tick(1'b0, 1'b0, 2'b01);
        n_checks++;
        if (bus.o_one_hot_q !== 4'b0100) begin
            n_errors++;
            $display("FAIL reg_hold_q: got %b expected 0100", bus.o_one_hot_q);
        end
        n_checks++;
        if (bus.o_valid_q !== 1'b0) begin
            n_errors++;
            $display("FAIL reg_hold_valid: got %b expected 0", bus.o_valid_q);
        end
        n_checks++;
        if (bus.o_one_hot !== 4'b0010) begin
            n_errors++;
            $display("FAIL reg_hold_comb: got %b expected 0010", bus.o_one_hot);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [4];
        seq[0] = 2'b11; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, seq[i]);
            n_checks++;
            if (bus.o_valid_q !== 1'b1 || bus.o_one_hot_q !== exp_one_hot(int'(seq[i]))) begin
                n_errors++;
                $display("FAIL back_to_back[%0d]: got q=%b v=%b expected q=%b v=1",
                         i, bus.o_one_hot_q, bus.o_valid_q, exp_one_hot(int'(seq[i])));
            end
        end
    endtask

`ifdef DECODER_2TO4_HIT_CNT_EN
    task automatic test_counters();
        logic [CW-1:0] got;
        int            want [4];
        tick(1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b1, 2'b00);
        tick(1'b0, 1'b1, 2'b01);
        tick(1'b0, 1'b1, 2'b01);
        tick(1'b0, 1'b1, 2'b11);
        want[0] = 1; want[1] = 2; want[2] = 0; want[3] = 1;
        for (int k = 0; k < 4; k++) begin
            got = bus.o_hit_cnt[k*CW +: CW];
            n_checks++;
            if (got !== CW'(want[k])) begin
                n_errors++;
                $display("FAIL counters line%0d: got %0d expected %0d", k, got, want[k]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [CW-1:0] got;
        tick(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 2'b00);
        got = bus.o_hit_cnt[0 +: CW];
        n_checks++;
        if (got !== CW'(CNT_MAX)) begin
            n_errors++;
            $display("FAIL saturation line0: got %0d expected %0d", got, CNT_MAX);
        end
        tick(1'b0, 1'b1, 2'b00);
        got = bus.o_hit_cnt[0 +: CW];
        n_checks++;
        if (got !== CW'(CNT_MAX)) begin
            n_errors++;
            $display("FAIL saturation_hold line0: got %0d expected %0d", got, CNT_MAX);
        end
    endtask
`endif

    task automatic test_midstream_reset();
        tick(1'b0, 1'b1, 2'b01);
        tick(1'b0, 1'b1, 2'b11);
        tick(1'b1, 1'b1, 2'b11);
        n_checks++;
        if (bus.o_valid_q !== 1'b0 || bus.o_one_hot_q !== 4'b0000) begin
            n_errors++;
            $display("FAIL midreset_clear: got q=%b v=%b expected q=0000 v=0", bus.o_one_hot_q, bus.o_valid_q);
        end
`ifdef DECODER_2TO4_HIT_CNT_EN
        n_checks++;
        if (bus.o_hit_cnt !== '0) begin
            n_errors++;
            $display("FAIL midreset_cnt: got %h expected 0", bus.o_hit_cnt);
        end
`endif
        tick(1'b0, 1'b1, 2'b10);
        n_checks++;
        if (bus.o_valid_q !== 1'b1 || bus.o_one_hot_q !== 4'b0100) begin
            n_errors++;
            $display("FAIL midreset_first: got q=%b v=%b expected q=0100 v=1", bus.o_one_hot_q, bus.o_valid_q);
        end
`ifdef DECODER_2TO4_HIT_CNT_EN
        n_checks++;
        if (bus.o_hit_cnt[2*CW +: CW] !== CW'(1)) begin
            n_errors++;
            $display("FAIL midreset_count line2: got %0d expected 1", bus.o_hit_cnt[2*CW +: CW]);
        end
`endif
    endtask

    task automatic test_random();
        logic       r;
        logic       en;
        logic [1:0] b;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 24) == 0);
            en = $urandom_range(0, 2) != 0;
            b  = 2'($urandom_range(0, 3));
            tick(r, en, b);
            n_checks++;
            if (bus.o_one_hot !== exp_one_hot(int'(b)) || bus.o_one_hot_q !== m_q || bus.o_valid_q !== m_vld) begin
                n_errors++;
                $display("FAIL random[%0d]: got oh=%b q=%b v=%b expected oh=%b q=%b v=%b",
                         i, bus.o_one_hot, bus.o_one_hot_q, bus.o_valid_q, exp_one_hot(int'(b)), m_q, m_vld);
            end
`ifdef DECODER_2TO4_HIT_CNT_EN
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (bus.o_hit_cnt[k*CW +: CW] !== CW'(m_cnt[k])) begin
                    n_errors++;
                    $display("FAIL random_cnt[%0d] line%0d: got %0d expected %0d",
                             i, k, bus.o_hit_cnt[k*CW +: CW], m_cnt[k]);
                end
            end
`endif
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        clk_run      = 1'b0;
        rst          = 1'b0;
        bus.i_en     = 1'b0;
        bus.i_binary = 2'b00;
        m_q          = 4'b0000;
        m_vld        = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;

        test_comb_sweep();
        clk_run = 1'b1;
        test_reset();
        test_registered();
        test_back_to_back();
`ifdef DECODER_2TO4_HIT_CNT_EN
        test_counters();
        test_saturation();
`endif
        test_midstream_reset();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
